// File: rtl/sd_arbiter.sv
// Shares one SD-card SPI byte master between the Z80 port and the AVR, with lock handover and per-owner read-back.
// Latency: accepted start -> spi_start next cycle; read byte lands in {zx,avr}_dout the cycle after spi_rdy returns.
// Backpressure: one pending byte per requester (newer overwrites); Z80 stalled via zx_busy, AVR via lock grant.
module sd_arbiter #(
    parameter int HANDOFF_GAP = 4
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       avr_lock_req,
    output logic       avr_lock_gnt,
    input  logic       avr_cs_n,
    input  logic       avr_start,
    input  logic [7:0] avr_din,
    output logic [7:0] avr_dout,
    input  logic       zx_cs_n,
    input  logic       zx_start,
    input  logic [7:0] zx_din,
    output logic [7:0] zx_dout,
    output logic       zx_busy,
    output logic       spi_start,
    output logic [7:0] spi_din,
    input  logic [7:0] spi_dout,
    input  logic       spi_rdy,
    output logic       sd_cs_n
);

    typedef enum logic [1:0] {
        S_ZX     = 2'd0,
        S_TO_AVR = 2'd1,
        S_AVR    = 2'd2,
        S_TO_ZX  = 2'd3
    } state_t;

    // Last gap cycle index; the handover edge happens on this count
    localparam logic [3:0] GAP_LAST = 4'(HANDOFF_GAP - 1);

    state_t     state;
    logic [3:0] gap_cnt;
    logic       start_d;
    logic       inflight;
    logic       tag_avr;
    logic       pend_zx;
    logic       pend_avr;
    logic [7:0] pend_zx_dat;
    logic [7:0] pend_avr_dat;

    logic       zx_issue;
    logic       avr_issue;
    logic       zx_latch;
    logic       avr_latch;
    logic [7:0] issue_dat;

    // spi_rdy is not trusted on the start cycle or the one after, where the master may not have dropped it yet
    logic inflight_clr;
    logic can_issue;
    logic xfer_done;

    assign inflight_clr = inflight && spi_rdy && !spi_start && !start_d;
    assign can_issue    = !inflight && !spi_start;
    // The bus counts as quiet from the byte-end cycle onward, so the gap starts at the spi_rdy rise
    assign xfer_done    = (!inflight || inflight_clr) && !spi_start;

    assign zx_busy = pend_zx || ((inflight || spi_start) && !tag_avr);

    // Decide this cycle's issue or pending-latch per requester, gated by current owner
    always_comb begin
        zx_issue  = 1'b0;
        avr_issue = 1'b0;
        zx_latch  = 1'b0;
        avr_latch = 1'b0;
        issue_dat = 8'hFF;
        case (state)
            S_ZX: begin
                if (zx_start) begin
                    if (can_issue) begin
                        zx_issue  = 1'b1;
                        issue_dat = zx_din;
                    end else begin
                        zx_latch = 1'b1;
                    end
                end else if (pend_zx && can_issue) begin
                    zx_issue  = 1'b1;
                    issue_dat = pend_zx_dat;
                end
            end
            S_AVR: begin
                if (zx_start) begin
                    zx_latch = 1'b1;
                end
                if (avr_start) begin
                    if (can_issue) begin
                        avr_issue = 1'b1;
                        issue_dat = avr_din;
                    end else begin
                        avr_latch = 1'b1;
                    end
                end else if (pend_avr && can_issue) begin
                    avr_issue = 1'b1;
                    issue_dat = pend_avr_dat;
                end
            end
            default: begin
                if (zx_start) begin
                    zx_latch = 1'b1;
                end
            end
        endcase
    end

    // Ownership FSM: handover waits for the bus to go quiet, then HANDOFF_GAP idle cycles with CS_n high
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_ZX;
            gap_cnt      <= 4'd0;
            avr_lock_gnt <= 1'b0;
            sd_cs_n      <= 1'b1;
        end else begin
            case (state)
                S_ZX:     sd_cs_n <= zx_cs_n;
                S_AVR:    sd_cs_n <= avr_cs_n;
                default:  sd_cs_n <= 1'b1;
            endcase

            case (state)
                S_ZX: begin
                    if (avr_lock_req) begin
                        state   <= S_TO_AVR;
                        gap_cnt <= 4'd0;
                    end
                end
                S_TO_AVR: begin
                    if (!avr_lock_req) begin
                        state   <= S_TO_ZX;
                        gap_cnt <= 4'd0;
                    end else if (!xfer_done) begin
                        gap_cnt <= 4'd0;
                    end else if (gap_cnt >= GAP_LAST) begin
                        state        <= S_AVR;
                        gap_cnt      <= 4'd0;
                        avr_lock_gnt <= 1'b1;
                    end else if (gap_cnt != 4'hF) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_AVR: begin
                    if (!avr_lock_req) begin
                        state        <= S_TO_ZX;
                        gap_cnt      <= 4'd0;
                        avr_lock_gnt <= 1'b0;
                    end
                end
                S_TO_ZX: begin
                    if (!xfer_done) begin
                        gap_cnt <= 4'd0;
                    end else if (gap_cnt >= GAP_LAST) begin
                        state   <= S_ZX;
                        gap_cnt <= 4'd0;
                    end else if (gap_cnt != 4'hF) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= S_ZX;
                    gap_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Byte datapath: issue pulse, pending slots, in-flight tracking and read-data return to the owner
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            spi_start    <= 1'b0;
            spi_din      <= 8'hFF;
            start_d      <= 1'b0;
            inflight     <= 1'b0;
            tag_avr      <= 1'b0;
            pend_zx      <= 1'b0;
            pend_avr     <= 1'b0;
            pend_zx_dat  <= 8'hFF;
            pend_avr_dat <= 8'hFF;
            zx_dout      <= 8'hFF;
            avr_dout     <= 8'hFF;
        end else begin
            spi_start <= zx_issue || avr_issue;
            start_d   <= spi_start;

            if (zx_issue || avr_issue) begin
                spi_din <= issue_dat;
                tag_avr <= avr_issue;
            end

            if (zx_latch) begin
                pend_zx     <= 1'b1;
                pend_zx_dat <= zx_din;
            end else if (zx_issue) begin
                pend_zx <= 1'b0;
            end

            // A queued AVR byte is dropped once the AVR has released the card
            if (state == S_TO_ZX) begin
                pend_avr <= 1'b0;
            end else if (avr_latch) begin
                pend_avr     <= 1'b1;
                pend_avr_dat <= avr_din;
            end else if (avr_issue) begin
                pend_avr <= 1'b0;
            end

            if (spi_start) begin
                inflight <= 1'b1;
            end else if (inflight_clr) begin
                inflight <= 1'b0;
                if (tag_avr) begin
                    avr_dout <= spi_dout;
                end else begin
                    zx_dout <= spi_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_arbiter.sv
// Bench for sd_arbiter: directed stimulus with a scoreboard of expected SPI bytes and read-back values.
// A behavioural SPI byte master returns queued responses 16 cycles after each spi_start.
// A monitor pops expectations whenever the DUT issues a byte or returns read data.
module tb_sd_arbiter;

    localparam int GAP = 4;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       avr_lock_req;
    logic       avr_lock_gnt;
    logic       avr_cs_n;
    logic       avr_start;
    logic [7:0] avr_din;
    logic [7:0] avr_dout;
    logic       zx_cs_n;
    logic       zx_start;
    logic [7:0] zx_din;
    logic [7:0] zx_dout;
    logic       zx_busy;
    logic       spi_start;
    logic [7:0] spi_din;
    logic [7:0] spi_dout;
    logic       spi_rdy;
    logic       sd_cs_n;

    always #5 fclk = ~fclk;

    sd_arbiter #(.HANDOFF_GAP(GAP)) dut (
        .fclk         (fclk),
        .rst_n        (rst_n),
        .avr_lock_req (avr_lock_req),
        .avr_lock_gnt (avr_lock_gnt),
        .avr_cs_n     (avr_cs_n),
        .avr_start    (avr_start),
        .avr_din      (avr_din),
        .avr_dout     (avr_dout),
        .zx_cs_n      (zx_cs_n),
        .zx_start     (zx_start),
        .zx_din       (zx_din),
        .zx_dout      (zx_dout),
        .zx_busy      (zx_busy),
        .spi_start    (spi_start),
        .spi_din      (spi_din),
        .spi_dout     (spi_dout),
        .spi_rdy      (spi_rdy),
        .sd_cs_n      (sd_cs_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_spi[$];
    logic [7:0] exp_zx[$];
    logic [7:0] exp_avr[$];
    logic [7:0] resp_q[$];

    task automatic chk1(input string name, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, want);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, want);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic tick;
        @(negedge fclk);
    endtask

    task automatic wait_rdy(input string name);
        int i;
        i = 0;
        while (!spi_rdy && i < 40) begin
            tick();
            i++;
        end
        chk1({name, "_rdy_timeout"}, spi_rdy, 1'b1);
    endtask

    task automatic wait_busy_low(input string name);
        int i;
        i = 0;
        while (zx_busy && i < 60) begin
            tick();
            i++;
        end
        chk1({name, "_busy_timeout"}, zx_busy, 1'b0);
    endtask

    task automatic wait_gnt(input string name);
        int i;
        i = 0;
        while (!avr_lock_gnt && i < 20) begin
            tick();
            i++;
        end
        chk1({name, "_gnt_timeout"}, avr_lock_gnt, 1'b1);
    endtask

    // Behavioural SPI byte master: busy for 16 cycles after each start, then returns the next queued byte
    initial begin
        spi_rdy  = 1'b1;
        spi_dout = 8'hFF;
        forever begin
            @(posedge fclk);
            #1;
            if (spi_start) begin
                spi_rdy = 1'b0;
                repeat (16) begin
                    @(posedge fclk);
                    #1;
                end
                if (resp_q.size() > 0) begin
                    spi_dout = resp_q.pop_front();
                end else begin
                    spi_dout = 8'hEE;
                end
                spi_rdy = 1'b1;
            end
        end
    end

    // Scoreboard monitor: compares every issued byte and every read-data return against the queues
    initial begin
        logic       prev_busy;
        logic [7:0] prev_avr;
        logic [7:0] want;
        prev_busy = 1'b0;
        prev_avr  = 8'hFF;
        forever begin
            @(posedge fclk);
            #2;
            if (rst_n) begin
                if (spi_start) begin
                    if (exp_spi.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spi_unexpected: got spi_start with %02h, expected none", spi_din);
                    end else begin
                        want = exp_spi.pop_front();
                        chk8("sb_spi_din", spi_din, want);
                    end
                end
                if (prev_busy && !zx_busy) begin
                    if (exp_zx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL zx_unexpected: got zx_dout %02h, expected none", zx_dout);
                    end else begin
                        want = exp_zx.pop_front();
                        chk8("sb_zx_dout", zx_dout, want);
                    end
                end
                if (avr_dout !== prev_avr) begin
                    if (exp_avr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL avr_unexpected: got avr_dout %02h, expected none", avr_dout);
                    end else begin
                        want = exp_avr.pop_front();
                        chk8("sb_avr_dout", avr_dout, want);
                    end
                end
            end
            prev_busy = zx_busy;
            prev_avr  = avr_dout;
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #60000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        int  starts;
        int  k;
        logic found;

        rst_n        = 1'b0;
        avr_lock_req = 1'b0;
        avr_cs_n     = 1'b1;
        avr_start    = 1'b0;
        avr_din      = 8'h00;
        zx_cs_n      = 1'b1;
        zx_start     = 1'b0;
        zx_din       = 8'h00;
        tick();
        tick();

        // Reset state
        chk1("rst_gnt", avr_lock_gnt, 1'b0);
        chk1("rst_cs", sd_cs_n, 1'b1);
        chk1("rst_start", spi_start, 1'b0);
        chk8("rst_spi_din", spi_din, 8'hFF);
        chk1("rst_busy", zx_busy, 1'b0);
        chk8("rst_avr_dout", avr_dout, 8'hFF);
        chk8("rst_zx_dout", zx_dout, 8'hFF);
        rst_n = 1'b1;
        tick();

        // 1: Z80 byte A5 -> 3C, CS follows Z80
        zx_cs_n = 1'b0;
        tick();
        chk1("t1_cs", sd_cs_n, 1'b0);
        resp_q.push_back(8'h3C);
        exp_spi.push_back(8'hA5);
        exp_zx.push_back(8'h3C);
        zx_din   = 8'hA5;
        zx_start = 1'b1;
        tick();
        zx_start = 1'b0;
        chk1("t1_start_next", spi_start, 1'b1);
        chk1("t1_busy", zx_busy, 1'b1);
        wait_busy_low("t1");
        chk8("t1_zx_dout", zx_dout, 8'h3C);

        // 2: handover to AVR while a Z80 byte is in flight
        resp_q.push_back(8'h77);
        exp_spi.push_back(8'h5A);
        exp_zx.push_back(8'h77);
        zx_din   = 8'h5A;
        zx_start = 1'b1;
        tick();
        zx_start = 1'b0;
        tick();
        avr_lock_req = 1'b1;
        wait_rdy("t2");
        chk1("t2_gnt_at_end", avr_lock_gnt, 1'b0);
        chk1("t2_cs_high", sd_cs_n, 1'b1);
        repeat (GAP - 1) tick();
        chk1("t2_gnt_early", avr_lock_gnt, 1'b0);
        tick();
        chk1("t2_gnt_on_time", avr_lock_gnt, 1'b1);
        chk8("t2_zx_dout", zx_dout, 8'h77);
        chk8("t2_avr_dout", avr_dout, 8'hFF);

        // 3: AVR byte 40 -> 95; Z80 byte FF held until the card returns to the Z80
        avr_cs_n = 1'b0;
        resp_q.push_back(8'h95);
        exp_spi.push_back(8'h40);
        exp_avr.push_back(8'h95);
        avr_din   = 8'h40;
        avr_start = 1'b1;
        tick();
        avr_start = 1'b0;
        chk1("t3_start", spi_start, 1'b1);
        resp_q.push_back(8'h66);
        exp_spi.push_back(8'hFF);
        exp_zx.push_back(8'h66);
        zx_din   = 8'hFF;
        zx_start = 1'b1;
        tick();
        zx_start = 1'b0;
        chk1("t3_zx_busy", zx_busy, 1'b1);
        chk1("t3_cs_avr", sd_cs_n, 1'b0);
        wait_rdy("t3");
        starts = 0;
        repeat (6) begin
            tick();
            if (spi_start) starts++;
        end
        chk_int("t3_no_zx_issue", starts, 0);
        chk8("t3_avr_dout", avr_dout, 8'h95);
        chk1("t3_busy_held", zx_busy, 1'b1);
        avr_lock_req = 1'b0;
        found = 1'b0;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) chk1("t3_gnt_drop", avr_lock_gnt, 1'b0);
            if (i == 2) chk1("t3_cs_gap", sd_cs_n, 1'b1);
            if (spi_start && !found) begin
                found = 1'b1;
                k = i;
            end
        end
        chk1("t3_zx_issued", found, 1'b1);
        chk1("t3_gap_respected", k > GAP, 1'b1);
        wait_busy_low("t3");
        chk8("t3_zx_dout", zx_dout, 8'h66);

        // 4: two Z80 starts during a byte -> only the newer one is sent
        resp_q.push_back(8'hA1);
        resp_q.push_back(8'hB2);
        exp_spi.push_back(8'h10);
        exp_spi.push_back(8'h22);
        exp_zx.push_back(8'hB2);
        zx_din   = 8'h10;
        zx_start = 1'b1;
        tick();
        zx_start = 1'b0;
        chk1("t4_start", spi_start, 1'b1);
        tick();
        zx_din   = 8'h11;
        zx_start = 1'b1;
        tick();
        zx_din   = 8'h22;
        tick();
        zx_start = 1'b0;
        wait_rdy("t4");
        tick();
        chk8("t4_first_dout", zx_dout, 8'hA1);
        chk1("t4_busy_pend", zx_busy, 1'b1);
        wait_busy_low("t4");
        chk8("t4_zx_dout", zx_dout, 8'hB2);

        // 5: AVR start without grant is ignored
        avr_din   = 8'hC3;
        avr_start = 1'b1;
        tick();
        avr_start = 1'b0;
        starts = 0;
        if (spi_start) starts++;
        repeat (4) begin
            tick();
            if (spi_start) starts++;
        end
        chk_int("t5_no_issue", starts, 0);
        chk8("t5_avr_dout", avr_dout, 8'h95);

        // 6: reset in the middle of an AVR byte
        avr_lock_req = 1'b1;
        wait_gnt("t6");
        resp_q.push_back(8'h24);
        exp_spi.push_back(8'h81);
        avr_din   = 8'h81;
        avr_start = 1'b1;
        tick();
        avr_start = 1'b0;
        chk1("t6_start", spi_start, 1'b1);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk1("t6_gnt", avr_lock_gnt, 1'b0);
        chk1("t6_cs", sd_cs_n, 1'b1);
        chk1("t6_busy", zx_busy, 1'b0);
        chk8("t6_avr_dout", avr_dout, 8'hFF);
        chk8("t6_zx_dout", zx_dout, 8'hFF);
        avr_lock_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk8("t6_late_avr_dout", avr_dout, 8'hFF);
        chk8("t6_late_zx_dout", zx_dout, 8'hFF);
        chk1("t6_late_gnt", avr_lock_gnt, 1'b0);

        // Every expectation consumed
        chk_int("end_spi_q", exp_spi.size(), 0);
        chk_int("end_zx_q", exp_zx.size(), 0);
        chk_int("end_avr_q", exp_avr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
